// File: rtl/multi_axis_motion_ctrl_pkg.sv
// Shared types and constants for the multi-axis step/dir motion controller.
package multi_axis_motion_ctrl_pkg;

    // Per-axis pulse generator state.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } axis_state_e;

    // Shortest legal step period in cycles; one high cycle plus one low cycle.
    localparam int unsigned MinPeriod = 2;

endpackage

// File: rtl/multi_axis_motion_ctrl_step_axis.sv
// One stepper axis: runs an exact number of step pulses at a fixed period.
module multi_axis_motion_ctrl_step_axis
    import multi_axis_motion_ctrl_pkg::*;
#(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              kill,
    input  logic [STEP_W-1:0] load_steps,
    input  logic [CNT_W-1:0]  load_period,
    output logic              step,
    output logic              busy,
    output logic              finishing,
    output logic [STEP_W-1:0] steps_left
);

    localparam logic [CNT_W-1:0] MinP = CNT_W'(MinPeriod);

    axis_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;    // cycles left in the current phase, minus one
    logic [CNT_W-1:0]  high_q, high_d;  // high phase length H
    logic [CNT_W-1:0]  low_q, low_d;    // low phase length P-H
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0]  period_c;
    logic [CNT_W-1:0]  half_c;

    assign period_c = (load_period < MinP) ? MinP : load_period;
    assign half_c   = period_c >> 1;

    // Next-state: load on accept, count out high/low phases, drop to idle on kill.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        low_d   = low_q;
        steps_d = steps_q;
        if (kill) begin
            // steps_left deliberately keeps its value so software can see how far the move got
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load) begin
                        steps_d = load_steps;
                        if (load_steps != '0) begin
                            state_d = StHigh;
                            high_d  = half_c;
                            low_d   = period_c - half_c;
                            cnt_d   = half_c - CNT_W'(1);
                        end
                    end
                end
                StHigh: begin
                    if (cnt_q == '0) begin
                        state_d = StLow;
                        cnt_d   = low_q - CNT_W'(1);
                        steps_d = steps_q - STEP_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StLow: begin
                    if (cnt_q == '0) begin
                        if (steps_q != '0) begin
                            state_d = StHigh;
                            cnt_d   = high_q - CNT_W'(1);
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
            steps_q <= steps_d;
        end
    end

    assign step       = (state_q == StHigh);
    assign busy       = (state_q != StIdle);
    // Last cycle of the last low phase: the axis goes idle on the coming edge.
    assign finishing  = (state_q == StLow) && (cnt_q == '0) && (steps_q == '0);
    assign steps_left = steps_q;

endmodule

// File: rtl/multi_axis_motion_ctrl.sv
// N-axis step/dir controller: command handshake, move-done pulse, manual button override.
module multi_axis_motion_ctrl
    import multi_axis_motion_ctrl_pkg::*;
#(
    parameter int unsigned N_AXES        = 2,
    parameter int unsigned STEP_W        = 16,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned MANUAL_PERIOD = 20000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     control_sel,
    input  logic [N_AXES-1:0]        man_fwd,
    input  logic [N_AXES-1:0]        man_rev,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [N_AXES*STEP_W-1:0] cmd_steps,
    input  logic [N_AXES*CNT_W-1:0]  cmd_period,
    input  logic [N_AXES-1:0]        cmd_dir,
    input  logic                     abort,
    output logic [N_AXES-1:0]        step_out,
    output logic [N_AXES-1:0]        dir_out,
    output logic [N_AXES-1:0]        busy,
    output logic                     done,
    output logic [N_AXES*STEP_W-1:0] steps_left
);

    localparam int unsigned      ManW    = $clog2(MANUAL_PERIOD);
    localparam logic [ManW-1:0] ManLast = ManW'(MANUAL_PERIOD - 1);
    localparam logic [ManW-1:0] ManHalf = ManW'(MANUAL_PERIOD / 2);

    logic              any_busy;
    logic              accept;
    logic              kill;
    logic              all_zero;
    logic              all_fin;
    logic              done_q, done_d;
    logic [N_AXES-1:0] prog_step;
    logic [N_AXES-1:0] axis_busy;
    logic [N_AXES-1:0] axis_fin;
    logic [N_AXES-1:0] man_move;
    logic [N_AXES-1:0] man_step;
    logic [N_AXES-1:0] man_on_q;
    logic [N_AXES-1:0] dir_q, dir_d;
    logic [ManW-1:0]   man_phase [N_AXES];
    logic [ManW-1:0]   man_cnt_q [N_AXES];
    logic [ManW-1:0]   man_cnt_d [N_AXES];

    assign any_busy  = |axis_busy;
    assign cmd_ready = reset && !control_sel && !any_busy && !abort;
    assign accept    = cmd_valid && cmd_ready;
    // Entering manual mode cancels a programmed move exactly like abort.
    assign kill      = abort || control_sel;

    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        multi_axis_motion_ctrl_step_axis #(
            .STEP_W (STEP_W),
            .CNT_W  (CNT_W)
        ) u_axis (
            .clock       (clock),
            .reset       (reset),
            .load        (accept),
            .kill        (kill),
            .load_steps  (cmd_steps[i*STEP_W +: STEP_W]),
            .load_period (cmd_period[i*CNT_W +: CNT_W]),
            .step        (prog_step[i]),
            .busy        (axis_busy[i]),
            .finishing   (axis_fin[i]),
            .steps_left  (steps_left[i*STEP_W +: STEP_W])
        );
    end

    // Move-done detection: either a no-op command or every busy axis on its final cycle.
    always_comb begin
        all_zero = 1'b1;
        all_fin  = any_busy;
        for (int i = 0; i < N_AXES; i++) begin
            if (cmd_steps[i*STEP_W +: STEP_W] != '0) begin
                all_zero = 1'b0;
            end
            if (axis_busy[i] && !axis_fin[i]) begin
                all_fin = 1'b0;
            end
        end
        done_d = (accept && all_zero) || (!kill && all_fin);
    end

    // Manual square wave per axis and direction tracking for both modes.
    always_comb begin
        for (int i = 0; i < N_AXES; i++) begin
            man_move[i]  = control_sel && (man_fwd[i] ^ man_rev[i]);
            // A fresh press restarts the wave at phase 0, i.e. high.
            man_phase[i] = man_on_q[i] ? man_cnt_q[i] : '0;
            man_step[i]  = man_move[i] && (man_phase[i] < ManHalf);
            if (!man_move[i] || (man_phase[i] == ManLast)) begin
                man_cnt_d[i] = '0;
            end else begin
                man_cnt_d[i] = man_phase[i] + ManW'(1);
            end
            dir_d[i] = dir_q[i];
            if (accept && (cmd_steps[i*STEP_W +: STEP_W] != '0)) begin
                dir_d[i] = cmd_dir[i];
            end else if (man_move[i]) begin
                dir_d[i] = man_fwd[i];
            end
        end
    end

    // Registers for done, direction and the manual wave counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q   <= 1'b0;
            dir_q    <= '0;
            man_on_q <= '0;
            for (int i = 0; i < N_AXES; i++) begin
                man_cnt_q[i] <= '0;
            end
        end else begin
            done_q   <= done_d;
            dir_q    <= dir_d;
            man_on_q <= man_move;
            for (int i = 0; i < N_AXES; i++) begin
                man_cnt_q[i] <= man_cnt_d[i];
            end
        end
    end

    // Output muxing between manual and programmed sources.
    always_comb begin
        step_out = control_sel ? man_step : prog_step;
        for (int i = 0; i < N_AXES; i++) begin
            dir_out[i] = man_move[i] ? man_fwd[i] : dir_q[i];
        end
        busy = axis_busy;
        done = done_q;
    end

endmodule

// File: tb/tb_multi_axis_motion_ctrl.sv
// Self-checking bench: directed move table, corner sequences, then random traffic vs a model.
module tb_multi_axis_motion_ctrl;

    localparam int N  = 2;
    localparam int SW = 16;
    localparam int CW = 32;
    localparam int MP = 40;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            control_sel = 1'b0;
    logic [N-1:0]    man_fwd = '0;
    logic [N-1:0]    man_rev = '0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [N*SW-1:0] cmd_steps = '0;
    logic [N*CW-1:0] cmd_period = '0;
    logic [N-1:0]    cmd_dir = '0;
    logic            abort = 1'b0;
    logic [N-1:0]    step_out;
    logic [N-1:0]    dir_out;
    logic [N-1:0]    busy;
    logic            done;
    logic [N*SW-1:0] steps_left;

    int n_checks = 0;
    int n_pass   = 0;

    multi_axis_motion_ctrl #(
        .N_AXES        (N),
        .STEP_W        (SW),
        .CNT_W         (CW),
        .MANUAL_PERIOD (MP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .control_sel (control_sel),
        .man_fwd     (man_fwd),
        .man_rev     (man_rev),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_steps   (cmd_steps),
        .cmd_period  (cmd_period),
        .cmd_dir     (cmd_dir),
        .abort       (abort),
        .step_out    (step_out),
        .dir_out     (dir_out),
        .busy        (busy),
        .done        (done),
        .steps_left  (steps_left)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // Each active axis is described by elapsed cycles into its move; outputs follow by arithmetic.
    int   m_act [N];
    int   m_pos [N];
    int   m_steps [N];
    int   m_p [N];
    int   m_h [N];
    int   m_left [N];
    int   m_run [N];
    logic m_dir [N];
    logic m_done;

    function automatic int shown_left(int i);
        int completed;
        if (m_act[i] == 0) return m_left[i];
        completed = (m_pos[i] >= m_h[i]) ? (m_pos[i] - m_h[i]) / m_p[i] + 1 : 0;
        return m_steps[i] - completed;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_pos[i] = 0; m_steps[i] = 0; m_p[i] = 2; m_h[i] = 1;
            m_left[i] = 0; m_run[i] = 0; m_dir[i] = 1'b0;
        end
        m_done = 1'b0;
    endtask

    function automatic logic model_any_act();
        for (int i = 0; i < N; i++) if (m_act[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_compare(input int cyc);
        logic [N-1:0]    e_step, e_dir;
        logic [N*SW-1:0] e_left;
        logic            e_ready;
        logic            mv;
        e_ready = !control_sel && !model_any_act() && !abort;
        for (int i = 0; i < N; i++) begin
            mv = control_sel && (man_fwd[i] ^ man_rev[i]);
            if (control_sel) e_step[i] = mv && ((m_run[i] % MP) < MP / 2);
            else e_step[i] = (m_act[i] != 0) && ((m_pos[i] % m_p[i]) < m_h[i]);
            e_dir[i] = mv ? man_fwd[i] : m_dir[i];
            e_left[i*SW +: SW] = SW'(shown_left(i));
        end
        check($sformatf("rnd_ready@%0d", cyc), cmd_ready, e_ready);
        check($sformatf("rnd_step@%0d", cyc), step_out, e_step);
        check($sformatf("rnd_dir@%0d", cyc), dir_out, e_dir);
        check($sformatf("rnd_busy@%0d", cyc), busy, {m_act[1] != 0, m_act[0] != 0});
        check($sformatf("rnd_done@%0d", cyc), done, m_done);
        check($sformatf("rnd_left@%0d", cyc), steps_left, e_left);
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_advance();
        logic ready, zero, was;
        int   s, p;
        ready = !control_sel && !model_any_act() && !abort;
        if (cmd_valid && ready) begin
            zero = 1'b1;
            for (int i = 0; i < N; i++) begin
                s = int'(cmd_steps[i*SW +: SW]);
                p = int'(cmd_period[i*CW +: CW]);
                m_left[i] = s;
                if (s != 0) begin
                    zero = 1'b0;
                    m_act[i] = 1; m_pos[i] = 0; m_steps[i] = s;
                    m_p[i] = (p < 2) ? 2 : p;
                    m_h[i] = m_p[i] / 2;
                    m_dir[i] = cmd_dir[i];
                end
            end
            m_done = zero;
        end else if (abort || control_sel) begin
            for (int i = 0; i < N; i++) begin
                if (m_act[i] != 0) begin
                    m_left[i] = shown_left(i);
                    m_act[i] = 0;
                end
            end
            m_done = 1'b0;
        end else begin
            was = model_any_act();
            for (int i = 0; i < N; i++) begin
                if (m_act[i] != 0) begin
                    m_pos[i]++;
                    if (m_pos[i] == m_steps[i] * m_p[i]) begin
                        m_act[i] = 0;
                        m_left[i] = 0;
                    end
                end
            end
            m_done = was && !model_any_act();
        end
        for (int i = 0; i < N; i++) begin
            if (control_sel && (man_fwd[i] ^ man_rev[i])) begin
                m_dir[i] = man_fwd[i];
                m_run[i]++;
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // ---------------- directed helpers ----------------
    typedef struct {
        logic [SW-1:0] s0, s1;
        logic [CW-1:0] p0, p1;
        logic [N-1:0]  dir;
        int            pulses0, pulses1;
        int            done_cyc;
        int            high0;
    } vec_t;

    vec_t vecs [5];

    // Offer one command; returns just after the accept edge, so the next negedge is cycle 1.
    task automatic issue(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                         input logic [CW-1:0] p0, input logic [CW-1:0] p1,
                         input logic [N-1:0] d);
        @(negedge clock);
        cmd_steps  = {s1, s0};
        cmd_period = {p1, p0};
        cmd_dir    = d;
        cmd_valid  = 1'b1;
        #1 check("issue_ready", cmd_ready, 1);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        int pc0, pc1, hi0, dcyc, ndone, bad;
        logic [N-1:0] prev;

        vecs[0] = '{16'd3, 16'd0, 32'd10, 32'd0, 2'b01, 3, 0, 31, 5};
        vecs[1] = '{16'd2, 16'd4, 32'd8,  32'd4, 2'b10, 2, 4, 17, 4};
        vecs[2] = '{16'd0, 16'd0, 32'd5,  32'd5, 2'b11, 0, 0, 1,  0};
        vecs[3] = '{16'd1, 16'd0, 32'd0,  32'd0, 2'b01, 1, 0, 3,  1};
        vecs[4] = '{16'd1, 16'd1, 32'd3,  32'd5, 2'b11, 1, 1, 6,  1};

        // Reset state
        #2;
        check("rst_step", step_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_left", steps_left, 0);
        check("rst_ready", cmd_ready, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Table of complete moves
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].s0, vecs[v].s1, vecs[v].p0, vecs[v].p1, vecs[v].dir);
            pc0 = 0; pc1 = 0; hi0 = 0; dcyc = 0; ndone = 0; prev = '0;
            for (int c = 1; c <= vecs[v].done_cyc + 3; c++) begin
                @(negedge clock); #1;
                if (step_out[0] && !prev[0]) pc0++;
                if (step_out[1] && !prev[1]) pc1++;
                if (pc0 == 1 && step_out[0]) hi0++;
                if (done) begin
                    ndone++;
                    if (dcyc == 0) dcyc = c;
                end
                prev = step_out;
            end
            check($sformatf("v%0d_pulses0", v), pc0, vecs[v].pulses0);
            check($sformatf("v%0d_pulses1", v), pc1, vecs[v].pulses1);
            check($sformatf("v%0d_high0", v), hi0, vecs[v].high0);
            check($sformatf("v%0d_done_cycle", v), dcyc, vecs[v].done_cyc);
            check($sformatf("v%0d_done_count", v), ndone, 1);
            check($sformatf("v%0d_idle", v), busy, 0);
            if (vecs[v].s0 != 0) check($sformatf("v%0d_dir0", v), dir_out[0], vecs[v].dir[0]);
        end

        // cmd_valid held through a move: blocked until done, taken on the edge after it
        @(negedge clock);
        cmd_steps = {16'd4, 16'd2}; cmd_period = {32'd4, 32'd8}; cmd_dir = 2'b00;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_steps = {16'd0, 16'd1}; cmd_period = {32'd0, 32'd6};
        bad = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock); #1;
            if (cmd_ready || done) bad++;
        end
        check("hold_blocked_cycles", bad, 0);
        @(negedge clock); #1;
        check("hold_done_c17", done, 1);
        check("hold_ready_c17", cmd_ready, 1);
        @(negedge clock); #1;
        check("hold_accept_busy", busy, 2'b01);
        check("hold_accept_left", steps_left, {16'd0, 16'd1});
        cmd_valid = 1'b0;
        repeat (10) @(negedge clock);

        // Abort during a high phase with two steps left
        issue(16'd3, 16'd0, 32'd10, 32'd0, 2'b01);
        repeat (12) @(negedge clock);
        #1;
        check("abort_pre_step", step_out[0], 1);
        check("abort_pre_left", steps_left[SW-1:0], 2);
        abort = 1'b1;
        #1 check("abort_ready", cmd_ready, 0);
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock); #1;
        check("abort_step", step_out, 0);
        check("abort_busy", busy, 0);
        check("abort_left", steps_left[SW-1:0], 2);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Asynchronous reset in the middle of a high phase
        issue(16'd3, 16'd0, 32'd10, 32'd0, 2'b01);
        repeat (2) @(negedge clock);
        #1 check("arst_pre_step", step_out[0], 1);
        reset = 1'b0;
        #1;
        check("arst_step", step_out, 0);
        check("arst_busy", busy, 0);
        check("arst_left", steps_left, 0);
        check("arst_ready", cmd_ready, 0);
        @(negedge clock);
        reset = 1'b1;

        // Manual mode: forward on axis 1, then both buttons
        @(negedge clock);
        control_sel = 1'b1; man_fwd = 2'b10; man_rev = 2'b00;
        for (int c = 0; c < 2 * MP; c++) begin
            #1;
            check($sformatf("man_step1@%0d", c), step_out[1], (c % MP) < MP / 2);
            check($sformatf("man_step0@%0d", c), step_out[0], 0);
            check($sformatf("man_dir1@%0d", c), dir_out[1], 1);
            check($sformatf("man_ready@%0d", c), cmd_ready, 0);
            check($sformatf("man_busy@%0d", c), busy, 0);
            @(negedge clock);
        end
        man_rev = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("man_both_step", step_out[1], 0);
            check("man_both_dir", dir_out[1], 1);
            check("man_both_ready", cmd_ready, 0);
            @(negedge clock);
        end
        control_sel = 1'b0; man_fwd = '0; man_rev = '0;

        // Randomized traffic against the reference model
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if ($urandom_range(0, 149) == 0) control_sel = ~control_sel;
            abort      = ($urandom_range(0, 39) == 0);
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_steps  = {SW'($urandom_range(0, 4)), SW'($urandom_range(0, 4))};
            cmd_period = {CW'($urandom_range(0, 9)), CW'($urandom_range(0, 9))};
            cmd_dir    = N'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                man_fwd = N'($urandom_range(0, 3));
                man_rev = N'($urandom_range(0, 3));
            end
            #1;
            model_compare(cyc);
            model_advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
